// File: rtl/nobl_sram_responder_pkg.sv
// Shared types and constants for the NoBL/ZBT SRAM responder.
// The operation encoding matches the RAM_WEn pin (0 = write, 1 = read).
package nobl_pkg;

    typedef enum logic {
        OP_WRITE = 1'b0,
        OP_READ  = 1'b1
    } op_e;

    // Enabled edges between a command and its data.
    localparam int unsigned PIPE_LAT = 2;

    // Address travels alongside the record because its width is a module parameter.
    typedef struct packed {
        logic valid;
        op_e  op;
        logic oe;
    } stage_t;

endpackage

// File: rtl/nobl_sram_mem.sv
// Single-port synchronous memory, WIDTH x 2^MEM_DEPTH, with a clock-enabled write
// and a clock-enabled registered read. Contents are never reset.
module nobl_sram_mem #(
    parameter int unsigned WIDTH     = 18,
    parameter int unsigned MEM_DEPTH = 10
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 we_i,
    input  logic                 re_i,
    input  logic [MEM_DEPTH-1:0] addr_i,
    input  logic [WIDTH-1:0]     wdata_i,
    output logic [WIDTH-1:0]     rdata_o
);

    logic [WIDTH-1:0] mem_q [2**MEM_DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // The read register holds its value between reads.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/nobl_sram_responder.sv
// Cycle-accurate NoBL/ZBT pipelined SRAM responder: command decode, burst advance,
// two-stage pipeline, clock-enable stall, read-data drive, contention flag and counters.
module nobl_sram_responder
    import nobl_pkg::*;
#(
    parameter int unsigned WIDTH     = 18,
    parameter int unsigned RAM_DEPTH = 19,
    parameter int unsigned MEM_DEPTH = 10
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [RAM_DEPTH-1:0] RAM_A,
    input  logic                 RAM_WEn,
    input  logic                 RAM_CENn,
    input  logic                 RAM_LDn,
    input  logic                 RAM_CE1n,
    input  logic                 RAM_OEn,
    input  logic [WIDTH-1:0]     RAM_D_i,
    input  logic                 RAM_D_ien,
    output logic [WIDTH-1:0]     RAM_D_o,
    output logic                 RAM_D_oe,
    output logic                 contention,
    output logic [31:0]          wr_count,
    output logic [31:0]          rd_count
);

    localparam int unsigned LAST = PIPE_LAT - 1;

    stage_t               stg_q  [PIPE_LAT];
    stage_t               stg_d  [PIPE_LAT];
    logic [MEM_DEPTH-1:0] addr_q [PIPE_LAT];
    logic [MEM_DEPTH-1:0] addr_d [PIPE_LAT];

    logic        oe_q, oe_d;
    logic        contention_q, contention_d;
    logic [31:0] wr_cnt_q, wr_cnt_d;
    logic [31:0] rd_cnt_q, rd_cnt_d;

    logic en;
    logic wr_fire;
    logic rd_fire;
    logic addr_hi_unused;

    // Upper address pins alias onto the stored range.
    assign addr_hi_unused = ^(RAM_A >> MEM_DEPTH);

    assign en      = !RAM_CENn;
    assign wr_fire = en && stg_q[LAST].valid && (stg_q[LAST].op == OP_WRITE);
    assign rd_fire = en && stg_q[LAST].valid && (stg_q[LAST].op == OP_READ);

    always_comb begin
        stg_d  = stg_q;
        addr_d = addr_q;

        // Burst continue keeps valid/op of the previous decode and steps the address;
        // a previous deselect therefore stays invalid.
        if (!RAM_LDn) begin
            stg_d[0].valid = !RAM_CE1n;
            stg_d[0].op    = op_e'(RAM_WEn);
            addr_d[0]      = RAM_A[MEM_DEPTH-1:0];
        end else begin
            addr_d[0] = addr_q[0] + 1'b1;
        end
        stg_d[0].oe = 1'b0;

        for (int unsigned i = 1; i < PIPE_LAT; i++) begin
            stg_d[i]    = stg_q[i-1];
            stg_d[i].oe = !RAM_OEn;
            addr_d[i]   = addr_q[i-1];
        end

        oe_d     = oe_q;
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        if (en) begin
            oe_d = rd_fire ? stg_q[LAST].oe : 1'b0;
        end
        if (wr_fire) begin
            wr_cnt_d = wr_cnt_q + 32'd1;
        end
        if (rd_fire) begin
            rd_cnt_d = rd_cnt_q + 32'd1;
        end

        contention_d = contention_q || (oe_q && RAM_D_ien);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < PIPE_LAT; i++) begin
                stg_q[i]  <= '0;
                addr_q[i] <= '0;
            end
            oe_q         <= 1'b0;
            contention_q <= 1'b0;
            wr_cnt_q     <= '0;
            rd_cnt_q     <= '0;
        end else begin
            if (en) begin
                for (int unsigned i = 0; i < PIPE_LAT; i++) begin
                    stg_q[i]  <= stg_d[i];
                    addr_q[i] <= addr_d[i];
                end
            end
            oe_q         <= oe_d;
            contention_q <= contention_d;
            wr_cnt_q     <= wr_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
        end
    end

    nobl_sram_mem #(
        .WIDTH     (WIDTH),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_mem (
        .clk     (clk),
        .rstn    (rstn),
        .we_i    (wr_fire),
        .re_i    (rd_fire),
        .addr_i  (addr_q[LAST]),
        .wdata_i (RAM_D_i),
        .rdata_o (RAM_D_o)
    );

    assign RAM_D_oe   = oe_q;
    assign contention = contention_q;
    assign wr_count   = wr_cnt_q;
    assign rd_count   = rd_cnt_q;

endmodule

// File: tb/tb_nobl_sram_responder.sv
// Directed bench for nobl_sram_responder: reset, write/read, wrapping burst, stall,
// read-after-write with aliasing, deselect, contention and mid-access reset.
module tb_nobl_sram_responder;

    logic        clk = 1'b0;
    logic        rstn;
    logic [18:0] RAM_A;
    logic        RAM_WEn, RAM_CENn, RAM_LDn, RAM_CE1n, RAM_OEn;
    logic [17:0] RAM_D_i;
    logic        RAM_D_ien;
    logic [17:0] RAM_D_o;
    logic        RAM_D_oe;
    logic        contention;
    logic [31:0] wr_count, rd_count;

    int total = 0;
    int bad   = 0;

    nobl_sram_responder #(
        .WIDTH     (18),
        .RAM_DEPTH (19),
        .MEM_DEPTH (10)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .RAM_A      (RAM_A),
        .RAM_WEn    (RAM_WEn),
        .RAM_CENn   (RAM_CENn),
        .RAM_LDn    (RAM_LDn),
        .RAM_CE1n   (RAM_CE1n),
        .RAM_OEn    (RAM_OEn),
        .RAM_D_i    (RAM_D_i),
        .RAM_D_ien  (RAM_D_ien),
        .RAM_D_o    (RAM_D_o),
        .RAM_D_oe   (RAM_D_oe),
        .contention (contention),
        .wr_count   (wr_count),
        .rd_count   (rd_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cmd(input logic wen, input logic [18:0] a);
        RAM_LDn  = 1'b0;
        RAM_CE1n = 1'b0;
        RAM_WEn  = wen;
        RAM_A    = a;
    endtask

    task automatic desel();
        RAM_LDn  = 1'b0;
        RAM_CE1n = 1'b1;
        RAM_WEn  = 1'b1;
    endtask

    localparam logic [17:0] DW  = 18'h1A5A5;
    localparam logic [17:0] D0  = 18'h0AAAA;
    localparam logic [17:0] D1  = 18'h15555;
    localparam logic [17:0] D2  = 18'h3C3C3;
    localparam logic [17:0] DRW = 18'h00111;

    initial begin
        rstn      = 1'b0;
        RAM_A     = '0;
        RAM_WEn   = 1'b1;
        RAM_CENn  = 1'b0;
        RAM_LDn   = 1'b0;
        RAM_CE1n  = 1'b1;
        RAM_OEn   = 1'b0;
        RAM_D_i   = '0;
        RAM_D_ien = 1'b0;

        // Reset then idle
        repeat (2) tick();
        rstn = 1'b1;
        repeat (3) tick();
        chk("rst_oe", {31'd0, RAM_D_oe}, 32'd0);
        chk("rst_do", {14'd0, RAM_D_o}, 32'd0);
        chk("rst_wr", wr_count, 32'd0);
        chk("rst_rd", rd_count, 32'd0);
        chk("rst_cont", {31'd0, contention}, 32'd0);

        // Single write at 0x005, data two edges later
        cmd(1'b0, 19'h00005); tick();
        desel();              tick();
        RAM_D_i = DW; RAM_D_ien = 1'b1; tick();
        RAM_D_ien = 1'b0;
        chk("wr1_cnt", wr_count, 32'd1);
        chk("wr1_oe", {31'd0, RAM_D_oe}, 32'd0);

        // Single read of 0x005
        cmd(1'b1, 19'h00005); tick();
        desel();              tick();
        chk("rd1_oe_early", {31'd0, RAM_D_oe}, 32'd0);
        tick();
        chk("rd1_data", {14'd0, RAM_D_o}, {14'd0, DW});
        chk("rd1_oe", {31'd0, RAM_D_oe}, 32'd1);
        chk("rd1_cnt", rd_count, 32'd1);
        tick();
        chk("idle_oe", {31'd0, RAM_D_oe}, 32'd0);
        chk("idle_hold", {14'd0, RAM_D_o}, {14'd0, DW});

        // Burst write 0x3FE, 0x3FF, 0x000
        cmd(1'b0, 19'h003FE); tick();
        RAM_LDn = 1'b1;       tick();
        RAM_D_i = D0; RAM_D_ien = 1'b1; tick();
        desel(); RAM_D_i = D1; tick();
        RAM_D_i = D2; tick();
        RAM_D_ien = 1'b0;
        chk("bw_cnt", wr_count, 32'd4);

        // Burst read from 0x3FE
        cmd(1'b1, 19'h003FE); tick();
        RAM_LDn = 1'b1;       tick();
        tick();
        chk("br_d0", {14'd0, RAM_D_o}, {14'd0, D0});
        chk("br_oe0", {31'd0, RAM_D_oe}, 32'd1);
        desel(); tick();
        chk("br_d1", {14'd0, RAM_D_o}, {14'd0, D1});
        tick();
        chk("br_d2_wrap", {14'd0, RAM_D_o}, {14'd0, D2});
        chk("br_oe2", {31'd0, RAM_D_oe}, 32'd1);
        tick();
        chk("br_end_oe", {31'd0, RAM_D_oe}, 32'd0);
        chk("br_cnt", rd_count, 32'd4);

        // Stall between read command and its data
        cmd(1'b1, 19'h00005); tick();
        desel(); RAM_CENn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_oe", {31'd0, RAM_D_oe}, 32'd0);
            chk("stall_do", {14'd0, RAM_D_o}, {14'd0, D2});
        end
        RAM_CENn = 1'b0; tick();
        chk("stall_n1_oe", {31'd0, RAM_D_oe}, 32'd0);
        tick();
        chk("stall_data", {14'd0, RAM_D_o}, {14'd0, DW});
        chk("stall_oe_on", {31'd0, RAM_D_oe}, 32'd1);
        RAM_CENn = 1'b1;
        repeat (2) tick();
        chk("stall2_oe", {31'd0, RAM_D_oe}, 32'd1);
        chk("stall2_do", {14'd0, RAM_D_o}, {14'd0, DW});
        chk("stall2_cnt", rd_count, 32'd5);
        RAM_CENn = 1'b0; tick();
        chk("stall_end_oe", {31'd0, RAM_D_oe}, 32'd0);

        // Read-after-write through an aliased address, then deselect
        cmd(1'b0, 19'h40005); tick();
        cmd(1'b1, 19'h00005); tick();
        desel(); RAM_D_i = DRW; RAM_D_ien = 1'b1; tick();
        RAM_D_ien = 1'b0; tick();
        chk("raw_data", {14'd0, RAM_D_o}, {14'd0, DRW});
        chk("raw_oe", {31'd0, RAM_D_oe}, 32'd1);
        chk("raw_wr", wr_count, 32'd5);
        chk("raw_rd", rd_count, 32'd6);
        tick();
        chk("desel_oe", {31'd0, RAM_D_oe}, 32'd0);
        chk("no_cont", {31'd0, contention}, 32'd0);

        // Contention while read data is driven
        cmd(1'b1, 19'h003FF); tick();
        desel(); tick();
        tick();
        chk("cont_rd", {14'd0, RAM_D_o}, {14'd0, D1});
        RAM_D_ien = 1'b1; tick();
        RAM_D_ien = 1'b0;
        chk("cont_set", {31'd0, contention}, 32'd1);
        repeat (3) tick();
        chk("cont_sticky", {31'd0, contention}, 32'd1);
        rstn = 1'b0; #1;
        chk("cont_clr", {31'd0, contention}, 32'd0);
        chk("rst2_do", {14'd0, RAM_D_o}, 32'd0);
        chk("rst2_wr", wr_count, 32'd0);
        tick();
        rstn = 1'b1;

        // Reset in the middle of a read discards it
        cmd(1'b1, 19'h00005); tick();
        desel();
        rstn = 1'b0; #2;
        rstn = 1'b1;
        repeat (3) tick();
        chk("discard_oe", {31'd0, RAM_D_oe}, 32'd0);
        chk("discard_rd", rd_count, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/nobl_sram_responder.md
Name: nobl_sram_responder

Overview:
- Synthesizable, cycle-accurate responder for the NoBL/ZBT pipelined SRAM pin interface driven by the external-SRAM FIFO controller.
- Used in place of the off-chip part, in simulation and on boards without SRAM.
- Samples the RAM_* control pins, models the two-cycle pipelined read/write latency, burst advance and clock-enable stall, and returns read data on the shared data bus.
- Flags bus contention and counts completed accesses for debug.

Parameters:
- WIDTH, 18, data bus width (18 or 36).
- RAM_DEPTH, 19, width of the RAM_A address pins.
- MEM_DEPTH, 10, address bits actually stored; 2^MEM_DEPTH words; upper RAM_A bits ignored (aliasing). Constraint: MEM_DEPTH <= RAM_DEPTH.

Ports:
- clk  in  1  single clock; all sampling on rising edge.
- rstn  in  1  asynchronous, active-low reset.
- RAM_A  in  RAM_DEPTH  address.
- RAM_WEn  in  1  0 = write, 1 = read.
- RAM_CENn  in  1  0 = clock enabled; 1 = stall.
- RAM_LDn  in  1  0 = load new address/op; 1 = burst advance.
- RAM_CE1n  in  1  0 = chip selected (only meaningful when RAM_LDn = 0).
- RAM_OEn  in  1  0 = output enable.
- RAM_D_i  in  WIDTH  write data driven by the controller.
- RAM_D_ien  in  1  controller is driving RAM_D_i.
- RAM_D_o  out  WIDTH  read data to the controller.
- RAM_D_oe  out  1  responder is driving RAM_D_o.
- contention  out  1  sticky; set when RAM_D_oe and RAM_D_ien are both 1 on a sampled edge.
- wr_count  out  32  completed writes.
- rd_count  out  32  completed reads.

Behaviour:
- Reset (rstn = 0, asynchronous):
  - Both pipeline stages invalid; burst address 0.
  - RAM_D_o = 0, RAM_D_oe = 0, contention = 0, wr_count = 0, rd_count = 0.
  - Memory contents are not reset.
  - Reset deasserted mid-access discards all in-flight operations.
- Pipeline: stage1 {valid, we, addr} and stage2 {valid, we, addr, oe}. All state advances only on edges where RAM_CENn = 0. With RAM_CENn = 1, every register, the memory, RAM_D_o, RAM_D_oe and both counters hold.
- Command decode at enabled edge N:
  - LDn = 0 and CE1n = 0: new op. stage1 <= {1, WEn, A[MEM_DEPTH-1:0]}.
  - LDn = 0 and CE1n = 1: deselect. stage1 <= invalid.
  - LDn = 1: burst continue. stage1 takes the previous op's type and addr + 1, wrapping modulo 2^MEM_DEPTH. If the previous op was a deselect, stage1 stays invalid.
  - stage2 <= stage1 on every enabled edge; stage2.oe <= ~RAM_OEn sampled at edge N+1.
- Write completion, enabled edge N+2 (stage2 valid write): mem[addr] <= RAM_D_i sampled at that edge; wr_count += 1; RAM_D_oe <= 0.
- Read completion, enabled edge N+2 (stage2 valid read): RAM_D_o <= mem[addr]; RAM_D_oe <= stage2.oe; rd_count += 1. Data is valid from just after edge N+2 until the next enabled edge.
- Idle (stage2 invalid) at an enabled edge: RAM_D_oe <= 0; RAM_D_o holds its last value.
- Read-after-write: a write at N followed by a read of the same address at N+1 returns the new data, because the write commits at N+2 and the read at N+3. A read at N followed by a write at N+1 to the same address returns the old data.
- Back-to-back mixed ops: full rate with no dead cycle; ZBT turnaround is the controller's responsibility.
- contention: checked on every edge, including stalled ones. Once set, clears only on reset.
- Counters: wrap at 2^32.

Decomposition:
- Shared package nobl_pkg: constants OP_READ/OP_WRITE, PIPE_LAT = 2, typedef for the pipeline-stage record.
- One sub-module, nobl_sram_mem: single-port synchronous memory, WIDTH x 2^MEM_DEPTH, one write port and one registered read port, both with clock enable; maps to block RAM.
- Top level holds the command decode, burst counter, pipeline, output register, contention check and counters.

Test Plan:
- Reset then idle: rstn pulse low with no commands -> RAM_D_oe = 0, RAM_D_o = 0, counters 0, contention 0.
- Single write then read: write A = 0x005, D = 0x1A5A5 (D presented 2 cycles later); read A = 0x005 with OEn = 0 -> RAM_D_o = 0x1A5A5 and RAM_D_oe = 1 exactly 2 cycles after the read command; wr_count = 1, rd_count = 1.
- Burst with wrap (MEM_DEPTH = 10): write 0x3FE with D0, then LDn = 1 for two cycles with D1, D2; burst read from 0x3FE -> D0, D1, D2 returned from addresses 0x3FE, 0x3FF, 0x000 on consecutive cycles.
- Stall: RAM_CENn = 1 for 3 cycles between a read command and its data -> data appears 2 enabled edges after the command (5 clocks), and RAM_D_o/RAM_D_oe hold throughout the stall.
- Read-after-write hazard and aliasing: write 0x40005 = 0x00111, next cycle read 0x00005 -> 0x00111; deselect (CE1n = 1) -> RAM_D_oe = 0 two cycles later.
- Contention: drive RAM_D_ien = 1 while read data is returned -> contention = 1 and stays 1 until rstn is asserted.
